// File: rtl/single_value_axil_regs.sv
// AXI4-Lite slave with four 32-bit registers; register 0 is exported to fabric
// as value_out, with a one-cycle value_update strobe on every valid write to it.
module single_value_axil_regs #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] C_RESET_VALUE      = 32'h0
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   value_out,
  output logic                            value_update
);

  localparam int         DW        = C_S_AXI_DATA_WIDTH;
  localparam int         AW        = C_S_AXI_ADDR_WIDTH;
  localparam int         SW        = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLV  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [DW-1:0] r_regs [4];

  wstate_t       r_wstate;
  logic          r_awready;
  logic          r_wready;
  logic          r_aw_valid;
  logic          r_w_valid;
  logic [AW-1:0] r_awaddr;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_wstrb;
  logic          r_bvalid;
  logic [1:0]    r_bresp;
  logic          r_value_update;

  rstate_t       r_rstate;
  logic          r_arready;
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;
  logic [1:0]    r_rresp;

  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_aw_have;
  logic          w_w_have;
  logic [AW-1:0] w_awaddr;
  logic [DW-1:0] w_wdata;
  logic [SW-1:0] w_wstrb;
  logic [1:0]    w_wr_idx;
  logic          w_aw_oor;
  logic          w_commit;
  logic          w_wr_en;
  logic [DW-1:0] w_merged;
  logic          w_ar_hs;
  logic [1:0]    w_rd_idx;
  logic          w_ar_oor;
  logic          w_unused;

  // A channel that handshakes this cycle counts as "latched" so that the
  // commit can happen on the same edge the second half arrives.
  assign w_aw_hs   = r_awready & S_AXI_AWVALID;
  assign w_w_hs    = r_wready & S_AXI_WVALID;
  assign w_aw_have = r_aw_valid | w_aw_hs;
  assign w_w_have  = r_w_valid | w_w_hs;
  assign w_awaddr  = w_aw_hs ? S_AXI_AWADDR : r_awaddr;
  assign w_wdata   = w_w_hs ? S_AXI_WDATA : r_wdata;
  assign w_wstrb   = w_w_hs ? S_AXI_WSTRB : r_wstrb;
  assign w_wr_idx  = w_awaddr[3:2];
  assign w_commit  = (r_wstate != W_RESP) & w_aw_have & w_w_have;
  assign w_wr_en   = w_commit & ~w_aw_oor;

  assign w_ar_hs   = r_arready & S_AXI_ARVALID;
  assign w_rd_idx  = S_AXI_ARADDR[3:2];

  generate
    if (AW > 4) begin : g_hi_bits
      assign w_aw_oor = |w_awaddr[AW-1:4];
      assign w_ar_oor = |S_AXI_ARADDR[AW-1:4];
    end else begin : g_no_hi_bits
      assign w_aw_oor = 1'b0;
      assign w_ar_oor = 1'b0;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < SW; gi++) begin : g_lane
      assign w_merged[gi*8 +: 8] = w_wstrb[gi] ? w_wdata[gi*8 +: 8]
                                               : r_regs[w_wr_idx][gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= C_RESET_VALUE[DW-1:0];
      end
    end else if (w_wr_en) begin
      r_regs[w_wr_idx] <= w_merged;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wstate       <= W_IDLE;
      r_awready      <= 1'b0;
      r_wready       <= 1'b0;
      r_aw_valid     <= 1'b0;
      r_w_valid      <= 1'b0;
      r_awaddr       <= '0;
      r_wdata        <= '0;
      r_wstrb        <= '0;
      r_bvalid       <= 1'b0;
      r_bresp        <= RESP_OKAY;
      r_value_update <= 1'b0;
    end else begin
      r_value_update <= 1'b0;
      case (r_wstate)
        W_IDLE, W_COLLECT: begin
          if (w_commit) begin
            r_wstate       <= W_RESP;
            r_awready      <= 1'b0;
            r_wready       <= 1'b0;
            r_aw_valid     <= 1'b0;
            r_w_valid      <= 1'b0;
            r_bvalid       <= 1'b1;
            r_bresp        <= w_aw_oor ? RESP_SLV : RESP_OKAY;
            r_value_update <= w_wr_en & (w_wr_idx == 2'd0);
          end else begin
            if (w_aw_hs) begin
              r_aw_valid <= 1'b1;
              r_awaddr   <= S_AXI_AWADDR;
            end
            if (w_w_hs) begin
              r_w_valid <= 1'b1;
              r_wdata   <= S_AXI_WDATA;
              r_wstrb   <= S_AXI_WSTRB;
            end
            r_awready <= ~w_aw_have;
            r_wready  <= ~w_w_have;
            r_wstate  <= (w_aw_have | w_w_have) ? W_COLLECT : W_IDLE;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        default: begin
          r_wstate <= W_IDLE;
        end
      endcase
    end
  end

  // Register reads use the pre-edge array contents, so a read accepted on the
  // commit edge of a write to the same offset returns the old value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else if (r_rstate == R_IDLE) begin
      if (w_ar_hs) begin
        r_rstate  <= R_DATA;
        r_arready <= 1'b0;
        r_rvalid  <= 1'b1;
        r_rdata   <= w_ar_oor ? '0 : r_regs[w_rd_idx];
        r_rresp   <= w_ar_oor ? RESP_SLV : RESP_OKAY;
      end else begin
        r_arready <= 1'b1;
      end
    end else begin
      if (S_AXI_RREADY) begin
        r_rstate  <= R_IDLE;
        r_rvalid  <= 1'b0;
        r_arready <= 1'b1;
      end
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign value_out     = r_regs[0];
  assign value_update  = r_value_update;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_awaddr[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_single_value_axil_regs.sv
// Directed bench for single_value_axil_regs: vector table for the register
// behaviour plus hand sequences for handshake ordering, concurrency and reset.
module tb_single_value_axil_regs;

  logic        ACLK;
  logic        ARESETN;
  logic [5:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [5:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [31:0] value_out;
  logic        value_update;

  single_value_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .C_RESET_VALUE(32'h0)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .value_out(value_out), .value_update(value_update)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    bit          is_wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  int n_vec  = 0;
  int n_bad  = 0;
  int n_pulse = 0;

  always @(negedge ACLK) begin
    if (value_update === 1'b1) n_pulse = n_pulse + 1;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec = n_vec + 1;
    n_bad = n_bad + 1;
    $display("FAIL %s: got timeout, expected handshake", nm);
  endtask

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    int  n;
    bit  aw_done;
    bit  w_done;
    bit  haw;
    bit  hw;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      haw = S_AXI_AWVALID && S_AXI_AWREADY;
      hw  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      if (haw) begin S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
      if (hw)  begin S_AXI_WVALID  = 1'b0; w_done  = 1'b1; end
      n++;
    end
    if (!(aw_done && w_done)) begin
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      timeout("write_addr_data");
      resp = 2'bxx;
      return;
    end
    n = 0;
    while (S_AXI_BVALID !== 1'b1 && n < 50) begin tick(); n++; end
    if (S_AXI_BVALID !== 1'b1) begin
      timeout("write_bvalid");
      resp = 2'bxx;
      return;
    end
    resp = S_AXI_BRESP;
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; n = 0;
    while (S_AXI_ARREADY !== 1'b1 && n < 50) begin tick(); n++; end
    if (S_AXI_ARREADY !== 1'b1) begin
      S_AXI_ARVALID = 1'b0;
      timeout("read_arready");
      d = 'x; resp = 2'bxx;
      return;
    end
    tick();
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (S_AXI_RVALID !== 1'b1 && n < 50) begin tick(); n++; end
    if (S_AXI_RVALID !== 1'b1) begin
      timeout("read_rvalid");
      d = 'x; resp = 2'bxx;
      return;
    end
    d = S_AXI_RDATA; resp = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
  endtask

  // One channel first, a gap, then the other; then a 5-cycle BREADY stall.
  task automatic split_write(input bit w_first, input int gap, input logic [5:0] a,
                             input logic [31:0] d);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = 4'hF;
    if (w_first) S_AXI_WVALID = 1'b1; else S_AXI_AWVALID = 1'b1;
    check("split_first_ready", w_first ? S_AXI_WREADY : S_AXI_AWREADY, 1);
    tick();
    if (w_first) S_AXI_WVALID = 1'b0; else S_AXI_AWVALID = 1'b0;
    check("split_ready_drop", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID},
          w_first ? 3'b100 : 3'b010);
    repeat (gap) tick();
    if (w_first) S_AXI_AWVALID = 1'b1; else S_AXI_WVALID = 1'b1;
    check("split_second_ready", w_first ? S_AXI_AWREADY : S_AXI_WREADY, 1);
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("split_bvalid_next", {S_AXI_BVALID, S_AXI_BRESP}, 3'b100);
    for (int i = 0; i < 5; i++) begin
      check("split_stall", {S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY}, 5'b10000);
      tick();
    end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check("split_release", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 3'b011);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;
    int          pulses_before;

    vecs[0]  = '{1'b1, 6'h00, 32'h00000001, 4'hF, 32'h0, 2'b00};
    vecs[1]  = '{1'b1, 6'h04, 32'h00000002, 4'hF, 32'h0, 2'b00};
    vecs[2]  = '{1'b1, 6'h08, 32'h00000003, 4'hF, 32'h0, 2'b00};
    vecs[3]  = '{1'b1, 6'h0C, 32'h00000004, 4'hF, 32'h0, 2'b00};
    vecs[4]  = '{1'b0, 6'h00, 32'h0, 4'h0, 32'h00000001, 2'b00};
    vecs[5]  = '{1'b0, 6'h04, 32'h0, 4'h0, 32'h00000002, 2'b00};
    vecs[6]  = '{1'b0, 6'h08, 32'h0, 4'h0, 32'h00000003, 2'b00};
    vecs[7]  = '{1'b0, 6'h0C, 32'h0, 4'h0, 32'h00000004, 2'b00};
    vecs[8]  = '{1'b1, 6'h04, 32'hAABBCCDD, 4'hF, 32'h0, 2'b00};
    vecs[9]  = '{1'b1, 6'h04, 32'h11223344, 4'h5, 32'h0, 2'b00};
    vecs[10] = '{1'b0, 6'h04, 32'h0, 4'h0, 32'hAA22CC44, 2'b00};
    vecs[11] = '{1'b1, 6'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b10};
    vecs[12] = '{1'b0, 6'h00, 32'h0, 4'h0, 32'h00000001, 2'b00};
    vecs[13] = '{1'b0, 6'h10, 32'h0, 4'h0, 32'h00000000, 2'b10};
    vecs[14] = '{1'b1, 6'h08, 32'h12345678, 4'h0, 32'h0, 2'b00};
    vecs[15] = '{1'b0, 6'h08, 32'h0, 4'h0, 32'h00000003, 2'b00};
    vecs[16] = '{1'b1, 6'h00, 32'hFFFFFFFF, 4'h0, 32'h0, 2'b00};
    vecs[17] = '{1'b0, 6'h00, 32'h0, 4'h0, 32'h00000001, 2'b00};
    vecs[18] = '{1'b1, 6'h24, 32'hCAFEF00D, 4'hF, 32'h0, 2'b10};
    vecs[19] = '{1'b0, 6'h3C, 32'h0, 4'h0, 32'h00000000, 2'b10};
    vecs[20] = '{1'b0, 6'h04, 32'h0, 4'h0, 32'hAA22CC44, 2'b00};

    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

    repeat (3) @(posedge ACLK);
    #1;
    check("reset_handshake_outputs",
          {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, value_update},
          6'b0);
    check("reset_resp_data", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 36'h0);
    check("reset_value_out", value_out, 32'h0);
    ARESETN = 1'b1;

    for (int i = 0; i < 4; i++) begin
      do_read(6'(i * 4), rd, rr);
      $display("reset read addr=%h data=%h resp=%b", 6'(i * 4), rd, rr);
      check("reset_read", {rd, rr}, {32'h0, 2'b00});
    end

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rr);
        $display("vec %0d write addr=%h data=%h strb=%h resp=%b",
                 i, vecs[i].addr, vecs[i].data, vecs[i].strb, rr);
        check($sformatf("vec%0d_bresp", i), rr, vecs[i].exp_resp);
      end else begin
        do_read(vecs[i].addr, rd, rr);
        $display("vec %0d read addr=%h data=%h resp=%b", i, vecs[i].addr, rd, rr);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
        check($sformatf("vec%0d_rresp", i), rr, vecs[i].exp_resp);
      end
    end
    check("table_value_out", value_out, 32'h00000001);
    check("table_update_pulses", n_pulse, 2);

    split_write(1'b1, 2, 6'h0C, 32'hA5A5A5A5);
    do_read(6'h0C, rd, rr);
    $display("split W-first read addr=0c data=%h resp=%b", rd, rr);
    check("w_first_readback", {rd, rr}, {32'hA5A5A5A5, 2'b00});

    split_write(1'b0, 2, 6'h08, 32'h5A5A0001);
    do_read(6'h08, rd, rr);
    $display("split AW-first read addr=08 data=%h resp=%b", rd, rr);
    check("aw_first_readback", {rd, rr}, {32'h5A5A0001, 2'b00});

    S_AXI_AWADDR = 6'h04; S_AXI_WDATA = 32'h0BADC0DE; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    check("same_cycle_ready", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("same_cycle_bvalid", {S_AXI_BVALID, S_AXI_BRESP}, 3'b100);
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    do_read(6'h04, rd, rr);
    $display("same-cycle write read addr=04 data=%h resp=%b", rd, rr);
    check("same_cycle_readback", {rd, rr}, {32'h0BADC0DE, 2'b00});
    check("split_no_pulses", n_pulse, 2);

    // Read of offset 0 accepted on the very edge a write to offset 0 commits.
    S_AXI_AWADDR = 6'h00; S_AXI_WDATA = 32'h00000055; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 6'h00;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    check("conc_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    $display("concurrent read addr=00 data=%h resp=%b", S_AXI_RDATA, S_AXI_RRESP);
    check("conc_old_value", {S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP}, {1'b1, 32'h1, 2'b00});
    check("conc_commit", {S_AXI_BVALID, value_update, value_out}, {2'b11, 32'h55});
    S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
    do_read(6'h00, rd, rr);
    $display("follow-up read addr=00 data=%h resp=%b", rd, rr);
    check("conc_new_value", {rd, rr}, {32'h55, 2'b00});
    check("conc_pulses", n_pulse, 3);

    // Reset while a read response is pending.
    pulses_before = n_pulse;
    S_AXI_ARADDR = 6'h04; S_AXI_ARVALID = 1'b1;
    check("rst_ar_ready", S_AXI_ARREADY, 1);
    tick();
    S_AXI_ARVALID = 1'b0;
    check("rst_rvalid_pending", S_AXI_RVALID, 1);
    #2 ARESETN = 1'b0;
    #1;
    check("rst_rvalid_drop", {S_AXI_RVALID, S_AXI_RDATA}, 33'h0);
    check("rst_value_out", value_out, 32'h0);
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("rst_no_response", {S_AXI_RVALID, S_AXI_BVALID}, 2'b00);
      tick();
    end
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
    do_read(6'h04, rd, rr);
    $display("post-reset read addr=04 data=%h resp=%b", rd, rr);
    check("rst_readback", {rd, rr}, {32'h0, 2'b00});
    check("rst_no_pulse", n_pulse, pulses_before);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/single_value_axil_regs.md
Name: single_value_axil_regs

Overview:
- AXI4-Lite slave register file: the responder end of the SingleValueIP S00_AXI control interface.
- Four 32-bit read/write registers at byte offsets 0x0, 0x4, 0x8 and 0xC.
- Register 0 is exported to fabric as the "single value", with a one-cycle update strobe on every write to it.
- The bus master (PS or VIP master) performs single-beat writes and reads against this block.

Parameters:
- C_S_AXI_DATA_WIDTH, 32: data width. Only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: byte-address width. Must be >= 4. Address bits above [3:2] must be zero for the access to be valid.
- C_RESET_VALUE, 32'h0: reset value of all four registers.

Ports:
- ACLK  in  1  single clock; all logic is on the rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- value_out  out  32  current contents of register 0.
- value_update  out  1  one-cycle pulse when register 0 is written.

Behaviour:
- Reset (asynchronous assert, synchronous release on ACLK):
  - All four registers = C_RESET_VALUE.
  - All READY, VALID and value_update outputs = 0.
  - BRESP, RRESP and RDATA = 0.
  - Reset asserted mid-transaction abandons the transaction. No response is produced after reset deasserts.
- Write path FSM: W_IDLE -> W_COLLECT -> W_RESP.
  - In W_IDLE and W_COLLECT, AWREADY = 1 while no address is latched, and WREADY = 1 while no data is latched.
  - AW and W are accepted independently, in either order or in the same cycle. Each is latched on its handshake, and its READY drops the following cycle.
  - When both address and data are latched, the register is updated on that edge and the FSM moves to W_RESP with BVALID = 1.
  - If AW and W handshake in the same cycle, BVALID asserts on the next cycle (one-cycle write latency).
  - Write update is per byte lane: lane i is written only when WSTRB[i] = 1. WSTRB = 0 leaves the register unchanged but still returns OKAY.
  - Address decode uses AWADDR[3:2]. If any AWADDR bit above [3:2] is nonzero, no register is written and BRESP = SLVERR (2'b10). Otherwise BRESP = OKAY (2'b00).
  - BVALID and BRESP stay stable until BREADY = 1. The FSM then returns to W_IDLE, and AWREADY and WREADY reassert on the next cycle.
  - Only one write is outstanding at a time. No new AW or W is accepted while in W_RESP.
- Read path FSM: R_IDLE -> R_DATA.
  - ARREADY = 1 in R_IDLE.
  - On the AR handshake, RDATA and RRESP are registered and RVALID = 1 on the next cycle (one-cycle read latency).
  - Decode uses ARADDR[3:2]. Any nonzero ARADDR bit above [3:2] returns RDATA = 0 and RRESP = SLVERR.
  - RVALID, RDATA and RRESP hold until RREADY = 1, then the FSM returns to R_IDLE. There is no back-to-back acceptance in the same cycle as RREADY.
- Read and write paths are independent and may be active concurrently.
  - A read accepted in the same cycle as a register update to the same address returns the pre-write value.
  - A read accepted after the update edge returns the new value.
- value_out:
  - Combinational copy of register 0. It changes on the edge where the write commits.
  - value_update = 1 for exactly the cycle after the commit edge of every valid write to offset 0x0, including WSTRB = 0.
  - value_update is not asserted for writes that return SLVERR.
- BREADY or RREADY held low indefinitely stalls only its own channel. The other channel is unaffected.

Test Plan:
- Sequential writes of 0x1, 0x2, 0x3, 0x4 to offsets 0x0, 0x4, 0x8, 0xC with WSTRB = 4'hF, then four reads -> each BRESP = OKAY, reads return 0x1..0x4 with RRESP = OKAY; value_out = 0x1; value_update pulses once.
- Reset: read all offsets immediately after reset deasserts -> RDATA = C_RESET_VALUE (0x0); all VALID outputs = 0 during reset.
- Byte strobes: write 0xAABBCCDD to 0x4 with WSTRB = 4'hF, then 0x11223344 with WSTRB = 4'b0101 -> reading 0x4 returns 0xAA22CC44.
- Handshake ordering: W presented 3 cycles before AW, then AW before W, then both in the same cycle -> exactly one write each; BVALID asserts the cycle after the second handshake; hold BREADY low 5 cycles -> BVALID and BRESP stable and AWREADY = 0 throughout.
- Out-of-range access (C_S_AXI_ADDR_WIDTH = 6): write to 0x10 -> BRESP = SLVERR, register 0 unchanged, no value_update; read of 0x10 -> RDATA = 0, RRESP = SLVERR.
- Concurrency and reset: read of 0x0 accepted in the same cycle a write of 0x55 to 0x0 commits -> read returns the old value and a following read returns 0x55; ARESETN pulsed low while RVALID is pending -> RVALID drops immediately and no response appears after release.
